// File: rtl/dram_if.sv
// dram_if: load/store port of the datapath data memory.
// The memory drives data_out; the execute/memory stage drives everything else.
interface dram_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24
);
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    output write,
    output read,
    output addr_in,
    output data_in,
    input  data_out
  );

  modport slave (
    input  write,
    input  read,
    input  addr_in,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/dram.sv
// dram: single-port, word-addressed data memory with a registered read port.
// Out-of-range addresses are checked against every address bit, so they never
// alias onto the array: writes to them are dropped and reads return zero.
// A synchronous active-low reset clears only the read register; the array
// keeps its contents.
// Optional feature macro: DRAM_WRITE_THROUGH_EN
//   defined     - a same-address write+read returns the data being written
//   not defined - a same-address write+read returns the old contents
module dram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24
) (
  input  logic   clk,
  input  logic   reset,
  dram_if.slave  bus
);

  // DEPTH must fit below 2**ADDR_W; the compare uses one extra bit so that a
  // DEPTH equal to 2**ADDR_W still works.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  // Address decode: full-width range check, low bits index the array.
  always_comb begin
    in_range = ({1'b0, bus.addr_in} < DEPTH_L);
    idx      = bus.addr_in[IDX_W-1:0];
  end

  // Array write; no reset so the array stays an inferable RAM.
  always_ff @(posedge clk) begin
    if (reset && bus.write && in_range) begin
      mem[idx] <= bus.data_in;
    end
  end

  // Registered read port; holds its value when read is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
    end else if (bus.read) begin
      if (!in_range) begin
        data_q <= '0;
`ifdef DRAM_WRITE_THROUGH_EN
      end else if (bus.write) begin
        data_q <= bus.data_in;
`endif
      end else begin
        data_q <= mem[idx];
      end
    end
  end

  assign bus.data_out = data_q;

endmodule

// File: tb/tb_dram.sv
// tb_dram: directed bench for the dram data memory.
module tb_dram;

  localparam int DEPTH  = 1024;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 24;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  dram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic wr, input logic rd,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din);
    reset       = rst;
    bus.write   = wr;
    bus.read    = rd;
    bus.addr_in = addr;
    bus.data_in = din;
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] expected);
    n_checks++;
    assert (bus.data_out === expected)
    else begin
      n_errors++;
      $error("FAIL %s: data_out=%h expected=%h", tag, bus.data_out, expected);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 24'd0, 24'd0);
    tick();
    tick();
    check("reset_state", 24'd0);

    // Write then read addr 100
    drive(1'b1, 1'b1, 1'b0, 24'd100, 24'd100);
    tick();
    drive(1'b1, 1'b0, 1'b1, 24'd100, 24'd0);
    tick();
    check("read_100", 24'd100);

    // Reset with read held clears data_out; contents retained
    drive(1'b0, 1'b0, 1'b1, 24'd100, 24'd0);
    tick();
    check("reset_during_read", 24'd0);
    drive(1'b1, 1'b0, 1'b1, 24'd100, 24'd0);
    tick();
    check("retained_100", 24'd100);

    // Preload addresses 0, 1, 3
    drive(1'b1, 1'b1, 1'b0, 24'd0, 24'h00A5A5);
    tick();
    drive(1'b1, 1'b1, 1'b0, 24'd1, 24'h111111);
    tick();
    drive(1'b1, 1'b1, 1'b0, 24'd3, 24'h000333);
    tick();

    // Write ABCDEF to 5, read held for 3 cycles, then hold with read low
    drive(1'b1, 1'b1, 1'b0, 24'd5, 24'hABCDEF);
    tick();
    drive(1'b1, 1'b0, 1'b1, 24'd5, 24'd0);
    tick();
    check("read5_c1", 24'hABCDEF);
    tick();
    check("read5_c2", 24'hABCDEF);
    tick();
    check("read5_c3", 24'hABCDEF);
    drive(1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
    tick();
    check("hold_no_read", 24'hABCDEF);

    // Out-of-range writes are discarded, reads return 0, no aliasing
    drive(1'b1, 1'b1, 1'b0, 24'd1024, 24'h123456);
    tick();
    drive(1'b1, 1'b1, 1'b0, 24'd1025, 24'h999999);
    tick();
    drive(1'b1, 1'b0, 1'b1, 24'd1024, 24'd0);
    tick();
    check("read_oor_1024", 24'd0);
    drive(1'b1, 1'b0, 1'b1, 24'd0, 24'd0);
    tick();
    check("no_alias_0", 24'h00A5A5);
    drive(1'b1, 1'b0, 1'b1, 24'd1, 24'd0);
    tick();
    check("no_alias_1", 24'h111111);
    drive(1'b1, 1'b0, 1'b1, 24'hFFFFFF, 24'd0);
    tick();
    check("read_oor_max", 24'd0);
    drive(1'b1, 1'b0, 1'b1, 24'd1023, 24'd0);
    drive(1'b1, 1'b1, 1'b0, 24'd1023, 24'h0BEEF0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 24'd1023, 24'd0);
    tick();
    check("read_top_1023", 24'h0BEEF0);

    // Same-address write+read collision
    drive(1'b1, 1'b1, 1'b0, 24'd9, 24'd7);
    tick();
    drive(1'b1, 1'b1, 1'b1, 24'd9, 24'd8);
    tick();
`ifdef DRAM_WRITE_THROUGH_EN
    check("collision_wt", 24'd8);
`else
    check("collision_rbw", 24'd7);
`endif
    drive(1'b1, 1'b0, 1'b1, 24'd9, 24'd0);
    tick();
    check("after_collision", 24'd8);

    // Back-to-back reads of different addresses
    drive(1'b1, 1'b0, 1'b1, 24'd5, 24'd0);
    tick();
    check("b2b_5", 24'hABCDEF);
    drive(1'b1, 1'b0, 1'b1, 24'd100, 24'd0);
    tick();
    check("b2b_100", 24'd100);

    // Reset on the same edge as a write drops the write
    drive(1'b0, 1'b1, 1'b1, 24'd3, 24'd55);
    tick();
    check("reset_with_write", 24'd0);
    drive(1'b1, 1'b0, 1'b1, 24'd3, 24'd0);
    tick();
    check("write_dropped_3", 24'h000333);

    drive(1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram.md
# dram

Single-port, word-addressed 24-bit data memory for the processor datapath. It serves load/store traffic from the execute/memory stage. Writes and reads are synchronous to one clock, and the read result is registered. The array is an inferable behavioural RAM of configurable depth behind a full 24-bit address bus, with range checking.

## Interface
- DEPTH, 1024: number of 24-bit words implemented; valid addresses 0 .. DEPTH-1.
- DATA_W, 24: word width; fixed at 24 in this design, parameterised for reuse.
- ADDR_W, 24: address bus width.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- write  input  1  write enable; stores data_in at addr_in on the rising edge.
- read  input  1  read enable; loads data_out from addr_in on the rising edge.
- addr_in  input  ADDR_W  word address (not byte address).
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.

## Operation
- Priority at each rising edge: reset (low) > write/read.
- Reset asserted (reset == 0):
  - data_out <= 0.
  - Array contents are retained.
  - write and read are ignored that cycle.
- write == 1, addr_in < DEPTH: mem[addr_in] <= data_in.
- write == 1, addr_in >= DEPTH: write discarded; no array cell changes.
- read == 1, addr_in < DEPTH: data_out <= mem[addr_in].
- read == 1, addr_in >= DEPTH: data_out <= 0.
- read == 0: data_out holds its previous value.
- write == 1 and read == 1 on the same edge:
  - The write is always performed.
  - The data returned depends on DRAM_WRITE_THROUGH_EN (see Configuration).
- Only the low log2(DEPTH) address bits index the array. The range check covers all ADDR_W bits, so out-of-range addresses never alias.
- Array contents after power-up are undefined (X in simulation) until written.

## Timing
- Write latency: data is visible to a read issued on the next rising edge or later.
- Read latency: 1 cycle. data_out reflects mem[addr_in] immediately after the rising edge where read == 1.
- Back-to-back reads on consecutive cycles are supported with no bubbles.
- No handshake and no busy signal: every request is accepted on the edge it is presented.
- Reset on the same edge as a read: data_out becomes 0, not memory data.
- Reset on the same edge as a write: the write is dropped.
- data_out changes only on rising edges; there is no combinational path from inputs to data_out.

## Configuration
- Macro: DRAM_WRITE_THROUGH_EN.
- Defined: simultaneous write and read to the same in-range address returns the new value; data_out <= data_in on that edge.
- Not defined: same case returns the old value; data_out <= mem[addr_in] as it was before the edge (read-before-write).
- Simultaneous write and read to different addresses is unaffected by the macro.

## Test plan
- Hold reset = 1; write = 1, addr_in = 100, data_in = 100 for one edge; then read = 1, addr_in = 100 -> data_out = 100 one edge later.
- Keep read = 1 and drop reset to 0 for one edge -> data_out = 0. Release reset and read addr 100 again -> data_out = 100 (contents retained).
- Write 24'hABCDEF to addr 5, then read addr 5 with read held for 3 cycles -> data_out = 24'hABCDEF each cycle. Drop read -> data_out holds 24'hABCDEF.
- Write 24'h123456 to addr DEPTH (1024) -> ignored. Read addr 1024 -> data_out = 0. Read addr 0 -> unchanged from its prior written value (no aliasing).
- Write 7 to addr 9. Next edge: write = 1, read = 1, addr 9, data_in = 8 -> data_out = 8 with DRAM_WRITE_THROUGH_EN, 7 without. A following read of addr 9 -> 8 in both builds.
- Assert reset while write = 1 to addr 3 with data_in = 55 -> subsequent read of addr 3 returns its pre-reset contents, not 55.
